e16_xdomain_rx_ctrl: RTL

- Receive-side controller for a toggle-handshake clock-domain crossing. Runs entirely in the destination clock domain.
- Synchronizes an incoming request toggle and captures the associated data word, which the sender holds stable.
- Presents the captured word to a local consumer over valid/ready.
- Returns an acknowledge toggle to the source domain.
- Sits between the multi-flop synchronizers and the destination-domain logic of an inter-domain link.

---
 rtl/e16_xrx_pkg.sv | 13 +
 rtl/e16_sync_bit.sv | 24 ++
 rtl/e16_xdomain_rx_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/e16_xrx_pkg.sv
// Shared types and constants for the e16 cross-domain receive controller.
// Optional macro E16_XRX_EARLY_ACK_EN is consumed by e16_xdomain_rx_ctrl only.
package e16_xrx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    localparam int unsigned SYNC_STAGES_DEFAULT = 2;
    localparam int unsigned SYNC_STAGES_MAX     = 4;

endpackage

// File: rtl/e16_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// Optional macro E16_XRX_EARLY_ACK_EN has no effect here.
module e16_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/e16_xdomain_rx_ctrl.sv
// Destination-side toggle-handshake CDC receiver: sync request, capture word, valid/ready, ack toggle.
// Define E16_XRX_EARLY_ACK_EN to return the ack on capture instead of on consumer accept.
module e16_xdomain_rx_ctrl
    import e16_xrx_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          tx_req_tgl,
    input  logic [DW-1:0] tx_data,
    output logic          tx_ack_tgl,
    output logic          rx_valid,
    output logic [DW-1:0] rx_data,
    input  logic          rx_ready,
    output logic          busy
);

    state_t state, state_nxt;
    logic   req_sync;
    logic   req_seen;
    logic   pending;
    logic   capture;
    logic   accept;
    logic   ack_flip;

    e16_sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_req_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (tx_req_tgl),
        .q       (req_sync)
    );

    assign pending = req_sync ^ req_seen;

    // A request pending while in VALID waits for the return to IDLE, so rx_data is never overwritten.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (pending && en) begin
                    capture   = 1'b1;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (rx_ready) begin
                    accept    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef E16_XRX_EARLY_ACK_EN
    assign ack_flip = capture;
`else
    assign ack_flip = accept;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_seen   <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            tx_ack_tgl <= 1'b0;
        end else begin
            state    <= state_nxt;
            rx_valid <= (state_nxt == VALID);
            if (capture) begin
                rx_data  <= tx_data;
                req_seen <= req_sync;
            end
            if (ack_flip) begin
                tx_ack_tgl <= ~tx_ack_tgl;
            end
        end
    end

    assign busy = (state != IDLE) || pending;

endmodule
